// File: rtl/adam_axil_demux_decerr.sv
// -----------------------------------------------------------------------------
// adam_axil_demux_decerr
// AXI-Lite 1-to-NO_MSTS address router with a built-in decode-error slave.
// Accesses outside every rule are answered locally with DECERR. While a
// direction has transactions in flight it stays locked to one target, so
// responses return in order. A pause handshake drains the block before
// acknowledging.
//
// Ports
//   clk, rst             fabric clock, synchronous active-high reset
//   pause_req/pause_ack  quiesce request / registered acknowledge
//   map_start/map_end    packed rule table, rule i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   s_aw/s_w/s_b         upstream write channels (slave side)
//   s_ar/s_r             upstream read channels (slave side)
//   m_*                  per-target channels, target i in slice i
// -----------------------------------------------------------------------------
module adam_axil_demux_decerr #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NO_MSTS    = 4,
    parameter int unsigned MAX_TRANS  = 7
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pause_req,
    output logic                            pause_ack,
    input  logic [NO_MSTS*ADDR_WIDTH-1:0]   map_start,
    input  logic [NO_MSTS*ADDR_WIDTH-1:0]   map_end,
    // upstream
    input  logic [ADDR_WIDTH-1:0]           s_aw_addr,
    input  logic                            s_aw_valid,
    output logic                            s_aw_ready,
    input  logic [DATA_WIDTH-1:0]           s_w_data,
    input  logic [DATA_WIDTH/8-1:0]         s_w_strb,
    input  logic                            s_w_valid,
    output logic                            s_w_ready,
    output logic [1:0]                      s_b_resp,
    output logic                            s_b_valid,
    input  logic                            s_b_ready,
    input  logic [ADDR_WIDTH-1:0]           s_ar_addr,
    input  logic                            s_ar_valid,
    output logic                            s_ar_ready,
    output logic [DATA_WIDTH-1:0]           s_r_data,
    output logic [1:0]                      s_r_resp,
    output logic                            s_r_valid,
    input  logic                            s_r_ready,
    // downstream targets
    output logic [NO_MSTS*ADDR_WIDTH-1:0]   m_aw_addr,
    output logic [NO_MSTS-1:0]              m_aw_valid,
    input  logic [NO_MSTS-1:0]              m_aw_ready,
    output logic [NO_MSTS*DATA_WIDTH-1:0]   m_w_data,
    output logic [NO_MSTS*DATA_WIDTH/8-1:0] m_w_strb,
    output logic [NO_MSTS-1:0]              m_w_valid,
    input  logic [NO_MSTS-1:0]              m_w_ready,
    input  logic [NO_MSTS*2-1:0]            m_b_resp,
    input  logic [NO_MSTS-1:0]              m_b_valid,
    output logic [NO_MSTS-1:0]              m_b_ready,
    output logic [NO_MSTS*ADDR_WIDTH-1:0]   m_ar_addr,
    output logic [NO_MSTS-1:0]              m_ar_valid,
    input  logic [NO_MSTS-1:0]              m_ar_ready,
    input  logic [NO_MSTS*DATA_WIDTH-1:0]   m_r_data,
    input  logic [NO_MSTS*2-1:0]            m_r_resp,
    input  logic [NO_MSTS-1:0]              m_r_valid,
    output logic [NO_MSTS-1:0]              m_r_ready
);

    localparam int unsigned TW = $clog2(NO_MSTS + 1);
    localparam int unsigned CW = $clog2(MAX_TRANS + 1);
    localparam logic [TW-1:0] ERR_T = TW'(NO_MSTS);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_TRANS);
    localparam logic [1:0]    DECERR = 2'b11;

    // Lowest matching rule wins; empty rules (start >= end) never match.
    function automatic logic [TW-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [TW-1:0] t;
        logic          found;
        t     = ERR_T;
        found = 1'b0;
        for (int i = 0; i < int'(NO_MSTS); i++) begin
            if (!found && addr >= map_start[i*ADDR_WIDTH +: ADDR_WIDTH]
                       && addr <  map_end[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                t     = TW'(i);
                found = 1'b1;
            end
        end
        return t;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] offset(input logic [ADDR_WIDTH-1:0] addr,
                                                     input logic [TW-1:0]         tgt);
        logic [ADDR_WIDTH-1:0] o;
        o = addr;
        for (int i = 0; i < int'(NO_MSTS); i++) begin
            if (tgt == TW'(i)) o = addr - map_start[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        return o;
    endfunction

    function automatic logic [CW-1:0] step(input logic [CW-1:0] cnt, input logic inc,
                                           input logic dec);
        logic [CW-1:0] n;
        n = cnt;
        if (inc && !dec)      n = cnt + CW'(1);
        else if (!inc && dec) n = cnt - CW'(1);
        return n;
    endfunction

    logic [TW-1:0] aw_tgt, ar_tgt, w_tgt, wlock_q, rlock_q;
    logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, wpend_q, wpend_d;
    logic [CW-1:0] errb_q, errb_d, errr_q, errr_d;
    logic          pause_ack_q, pause_ack_d;
    logic          aw_acc, ar_acc, aw_sel_rdy, ar_sel_rdy, w_sel_rdy, w_en;
    logic          aw_hs, ar_hs, w_hs, b_hs, r_hs;

    // Address decode and AW/AR pass-through.
    always_comb begin
        aw_tgt     = decode(s_aw_addr);
        ar_tgt     = decode(s_ar_addr);
        aw_acc     = !rst && !pause_req && (wcnt_q < MAX_C) &&
                     (wcnt_q == '0 || aw_tgt == wlock_q);
        ar_acc     = !rst && !pause_req && (rcnt_q < MAX_C) &&
                     (rcnt_q == '0 || ar_tgt == rlock_q);
        aw_sel_rdy = (aw_tgt == ERR_T);
        ar_sel_rdy = (ar_tgt == ERR_T);
        m_aw_valid = '0;
        m_ar_valid = '0;
        for (int i = 0; i < int'(NO_MSTS); i++) begin
            if (aw_tgt == TW'(i)) aw_sel_rdy = m_aw_ready[i];
            if (ar_tgt == TW'(i)) ar_sel_rdy = m_ar_ready[i];
            m_aw_valid[i] = s_aw_valid && aw_acc && (aw_tgt == TW'(i));
            m_ar_valid[i] = s_ar_valid && ar_acc && (ar_tgt == TW'(i));
        end
        s_aw_ready = aw_acc && aw_sel_rdy;
        s_ar_ready = ar_acc && ar_sel_rdy;
        aw_hs      = s_aw_valid && s_aw_ready;
        ar_hs      = s_ar_valid && s_ar_ready;
        m_aw_addr  = {NO_MSTS{offset(s_aw_addr, aw_tgt)}};
        m_ar_addr  = {NO_MSTS{offset(s_ar_addr, ar_tgt)}};
    end

    // W follows an accepted AW; with none pending it may ride the AW accepted this cycle.
    always_comb begin
        w_en      = !rst && (wpend_q != '0 || aw_hs);
        w_tgt     = (wpend_q != '0) ? wlock_q : aw_tgt;
        w_sel_rdy = (w_tgt == ERR_T);
        m_w_valid = '0;
        for (int i = 0; i < int'(NO_MSTS); i++) begin
            if (w_tgt == TW'(i)) w_sel_rdy = m_w_ready[i];
            m_w_valid[i] = s_w_valid && w_en && (w_tgt == TW'(i));
        end
        s_w_ready = w_en && w_sel_rdy;
        w_hs      = s_w_valid && s_w_ready;
        m_w_data  = {NO_MSTS{s_w_data}};
        m_w_strb  = {NO_MSTS{s_w_strb}};
    end

    // B/R return only from the locked target while transactions are in flight.
    always_comb begin
        s_b_valid = 1'b0;
        s_b_resp  = 2'b00;
        m_b_ready = '0;
        s_r_valid = 1'b0;
        s_r_resp  = 2'b00;
        s_r_data  = '0;
        m_r_ready = '0;
        if (!rst && wcnt_q != '0) begin
            if (wlock_q == ERR_T) begin
                s_b_valid = (errb_q != '0);
                s_b_resp  = DECERR;
            end
            for (int i = 0; i < int'(NO_MSTS); i++) begin
                if (wlock_q == TW'(i)) begin
                    s_b_valid    = m_b_valid[i];
                    s_b_resp     = m_b_resp[i*2 +: 2];
                    m_b_ready[i] = s_b_ready;
                end
            end
        end
        if (!rst && rcnt_q != '0) begin
            if (rlock_q == ERR_T) begin
                s_r_valid = (errr_q != '0);
                s_r_resp  = DECERR;
            end
            for (int i = 0; i < int'(NO_MSTS); i++) begin
                if (rlock_q == TW'(i)) begin
                    s_r_valid    = m_r_valid[i];
                    s_r_resp     = m_r_resp[i*2 +: 2];
                    s_r_data     = m_r_data[i*DATA_WIDTH +: DATA_WIDTH];
                    m_r_ready[i] = s_r_ready;
                end
            end
        end
        b_hs = s_b_valid && s_b_ready;
        r_hs = s_r_valid && s_r_ready;
    end

    // Counter next-state; pause_ack looks at post-update counts so it rises right after the last response.
    always_comb begin
        wcnt_d      = step(wcnt_q, aw_hs, b_hs);
        rcnt_d      = step(rcnt_q, ar_hs, r_hs);
        wpend_d     = step(wpend_q, aw_hs, w_hs);
        errb_d      = step(errb_q, w_hs && w_tgt == ERR_T, b_hs && wlock_q == ERR_T);
        errr_d      = step(errr_q, ar_hs && ar_tgt == ERR_T, r_hs && rlock_q == ERR_T);
        pause_ack_d = pause_req && wcnt_d == '0 && rcnt_d == '0 && wpend_d == '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            wpend_q     <= '0;
            errb_q      <= '0;
            errr_q      <= '0;
            wlock_q     <= '0;
            rlock_q     <= '0;
            pause_ack_q <= 1'b0;
        end else begin
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            wpend_q     <= wpend_d;
            errb_q      <= errb_d;
            errr_q      <= errr_d;
            pause_ack_q <= pause_ack_d;
            if (aw_hs) wlock_q <= aw_tgt;
            if (ar_hs) rlock_q <= ar_tgt;
        end
    end

    assign pause_ack = pause_ack_q;

endmodule

// File: tb/tb_adam_axil_demux_decerr.sv
// Directed bench for adam_axil_demux_decerr. A second instance with
// MAX_TRANS=2 shares all inputs and is used for the outstanding-limit case.
module tb_adam_axil_demux_decerr;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NM = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              pause_req;
    logic [NM*AW-1:0]  map_start, map_end;
    logic [AW-1:0]     s_aw_addr, s_ar_addr;
    logic              s_aw_valid, s_w_valid, s_b_ready, s_ar_valid, s_r_ready;
    logic [DW-1:0]     s_w_data;
    logic [DW/8-1:0]   s_w_strb;
    logic [NM-1:0]     m_aw_ready, m_w_ready, m_b_valid, m_ar_ready, m_r_valid;
    logic [NM*2-1:0]   m_b_resp, m_r_resp;
    logic [NM*DW-1:0]  m_r_data;

    // main instance outputs
    logic              pause_ack, s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid;
    logic [1:0]        s_b_resp, s_r_resp;
    logic [DW-1:0]     s_r_data;
    logic [NM*AW-1:0]  m_aw_addr, m_ar_addr;
    logic [NM*DW-1:0]  m_w_data;
    logic [NM*DW/8-1:0] m_w_strb;
    logic [NM-1:0]     m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready;
    // limited instance outputs
    logic              l_pause_ack, l_s_aw_ready, l_s_w_ready, l_s_b_valid, l_s_ar_ready, l_s_r_valid;
    logic [1:0]        l_s_b_resp, l_s_r_resp;
    logic [DW-1:0]     l_s_r_data;
    logic [NM*AW-1:0]  l_m_aw_addr, l_m_ar_addr;
    logic [NM*DW-1:0]  l_m_w_data;
    logic [NM*DW/8-1:0] l_m_w_strb;
    logic [NM-1:0]     l_m_aw_valid, l_m_w_valid, l_m_b_ready, l_m_ar_valid, l_m_r_ready;

    int checks = 0;
    int errors = 0;
    logic [1:0]    exp_b[$];
    logic [DW+1:0] exp_r[$];

    always #5 clk = ~clk;

    adam_axil_demux_decerr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_MSTS(NM), .MAX_TRANS(7)) u_dut (
        .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
        .map_start(map_start), .map_end(map_end),
        .s_aw_addr(s_aw_addr), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
        .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
        .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
        .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
        .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
        .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
        .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
        .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready)
    );

    adam_axil_demux_decerr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_MSTS(NM), .MAX_TRANS(2)) u_lim (
        .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(l_pause_ack),
        .map_start(map_start), .map_end(map_end),
        .s_aw_addr(s_aw_addr), .s_aw_valid(s_aw_valid), .s_aw_ready(l_s_aw_ready),
        .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(l_s_w_ready),
        .s_b_resp(l_s_b_resp), .s_b_valid(l_s_b_valid), .s_b_ready(s_b_ready),
        .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(l_s_ar_ready),
        .s_r_data(l_s_r_data), .s_r_resp(l_s_r_resp), .s_r_valid(l_s_r_valid), .s_r_ready(s_r_ready),
        .m_aw_addr(l_m_aw_addr), .m_aw_valid(l_m_aw_valid), .m_aw_ready(m_aw_ready),
        .m_w_data(l_m_w_data), .m_w_strb(l_m_w_strb), .m_w_valid(l_m_w_valid), .m_w_ready(m_w_ready),
        .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(l_m_b_ready),
        .m_ar_addr(l_m_ar_addr), .m_ar_valid(l_m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(l_m_r_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_b(input string tag, input logic [1:0] obs);
        logic [1:0] e;
        e = 2'bxx;
        if (exp_b.size() != 0) e = exp_b.pop_front();
        chk(tag, 64'(obs), 64'(e));
    endtask

    task automatic pop_r(input string tag, input logic [1:0] resp, input logic [DW-1:0] data);
        logic [DW+1:0] e;
        e = 'x;
        if (exp_r.size() != 0) e = exp_r.pop_front();
        chk(tag, 64'({resp, data}), 64'(e));
    endtask

    task automatic idle();
        pause_req  = 1'b0;
        s_aw_valid = 1'b0; s_aw_addr = '0;
        s_w_valid  = 1'b0; s_w_data  = '0; s_w_strb = '1;
        s_ar_valid = 1'b0; s_ar_addr = '0;
        s_b_ready  = 1'b0; s_r_ready = 1'b0;
        m_aw_ready = '1; m_w_ready = '1; m_ar_ready = '1;
        m_b_valid  = '0; m_b_resp = '0;
        m_r_valid  = '0; m_r_resp = '0; m_r_data = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_b.delete();
        exp_r.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        map_start = '0; map_end = '0;
        map_start[0*AW +: AW] = 32'h0000_0000; map_end[0*AW +: AW] = 32'h0000_1000;
        map_start[1*AW +: AW] = 32'h0000_1000; map_end[1*AW +: AW] = 32'h0000_2000;
        map_start[2*AW +: AW] = 32'h0000_2000; map_end[2*AW +: AW] = 32'h0000_3000;
        map_start[3*AW +: AW] = 32'h0000_5000; map_end[3*AW +: AW] = 32'h0000_5000;

        // reset: ready/valid outputs held low even with upstream requests present
        idle();
        rst = 1'b1;
        s_aw_valid = 1'b1; s_aw_addr = 32'h1234;
        s_ar_valid = 1'b1; s_ar_addr = 32'h0040;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_aw_ready", 64'(s_aw_ready), 64'd0);
        chk("rst_ar_ready", 64'(s_ar_ready), 64'd0);
        chk("rst_m_aw_valid", 64'(m_aw_valid), 64'd0);
        chk("rst_pause_ack", 64'(pause_ack), 64'd0);
        chk("rst_b_valid", 64'(s_b_valid), 64'd0);
        chk("rst_r_valid", 64'(s_r_valid), 64'd0);
        idle();
        rst = 1'b0;

        // route/offset: write 0x1234 to target 1
        @(negedge clk);
        s_aw_valid = 1'b1; s_aw_addr = 32'h1234;
        s_w_valid = 1'b1; s_w_data = 32'hDEAD_BEEF;
        exp_b.push_back(2'b00);
        #1;
        chk("t1_aw_ready", 64'(s_aw_ready), 64'd1);
        chk("t1_m_aw_valid", 64'(m_aw_valid), 64'b0010);
        chk("t1_m_aw_addr", 64'(m_aw_addr[1*AW +: AW]), 64'h234);
        chk("t1_m_w_valid", 64'(m_w_valid), 64'b0010);
        chk("t1_m_w_data", 64'(m_w_data[1*DW +: DW]), 64'hDEAD_BEEF);
        @(negedge clk);
        idle();
        m_b_valid = 4'b0010; s_b_ready = 1'b1;
        #1;
        chk("t1_b_valid", 64'(s_b_valid), 64'd1);
        chk("t1_m_b_ready", 64'(m_b_ready), 64'b0010);
        pop_b("t1_b_resp", s_b_resp);

        // decode error read
        @(negedge clk);
        idle();
        s_ar_valid = 1'b1; s_ar_addr = 32'hF000_0000;
        exp_r.push_back({2'b11, 32'h0});
        #1;
        chk("t2_ar_ready", 64'(s_ar_ready), 64'd1);
        chk("t2_m_ar_valid", 64'(m_ar_valid), 64'd0);
        chk("t2_r_early", 64'(s_r_valid), 64'd0);
        @(negedge clk);
        idle();
        s_r_ready = 1'b1;
        #1;
        chk("t2_r_valid", 64'(s_r_valid), 64'd1);
        pop_r("t2_r_resp_data", s_r_resp, s_r_data);
        @(negedge clk);
        idle();
        #1;
        chk("t2_r_done", 64'(s_r_valid), 64'd0);

        // decode error write via the empty rule 3
        @(negedge clk);
        s_aw_valid = 1'b1; s_aw_addr = 32'h5000;
        s_w_valid = 1'b1; s_w_data = 32'h1111_2222;
        exp_b.push_back(2'b11);
        #1;
        chk("te_aw_ready", 64'(s_aw_ready), 64'd1);
        chk("te_w_ready", 64'(s_w_ready), 64'd1);
        chk("te_m_valid", 64'({m_aw_valid, m_w_valid}), 64'd0);
        @(negedge clk);
        idle();
        s_b_ready = 1'b1;
        #1;
        chk("te_b_valid", 64'(s_b_valid), 64'd1);
        pop_b("te_b_resp", s_b_resp);

        // pause drain with one read outstanding to target 0
        @(negedge clk);
        idle();
        s_ar_valid = 1'b1; s_ar_addr = 32'h0040;
        exp_r.push_back({2'b00, 32'h55});
        #1;
        chk("t5_ar_ready", 64'(s_ar_ready), 64'd1);
        chk("t5_m_ar_addr", 64'(m_ar_addr[0*AW +: AW]), 64'h40);
        @(negedge clk);
        pause_req = 1'b1; s_ar_addr = 32'h0044;
        #1;
        chk("t5_blocked_ready", 64'(s_ar_ready), 64'd0);
        chk("t5_blocked_valid", 64'(m_ar_valid), 64'd0);
        chk("t5_ack_0a", 64'(pause_ack), 64'd0);
        @(negedge clk);
        m_r_valid = 4'b0001; m_r_data[0*DW +: DW] = 32'h55; s_r_ready = 1'b1;
        #1;
        chk("t5_ack_0b", 64'(pause_ack), 64'd0);
        chk("t5_r_valid", 64'(s_r_valid), 64'd1);
        chk("t5_m_r_ready", 64'(m_r_ready), 64'b0001);
        pop_r("t5_r", s_r_resp, s_r_data);
        @(negedge clk);
        m_r_valid = '0; s_r_ready = 1'b0; s_ar_valid = 1'b0;
        #1;
        chk("t5_ack_1", 64'(pause_ack), 64'd1);
        pause_req = 1'b0;
        @(negedge clk);
        #1;
        chk("t5_ack_drop", 64'(pause_ack), 64'd0);

        // W presented three cycles ahead of its AW (target 2)
        idle();
        s_w_valid = 1'b1; s_w_data = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("t6_w_ready_early", 64'(s_w_ready), 64'd0);
            chk("t6_m_w_valid_early", 64'(m_w_valid), 64'd0);
        end
        @(negedge clk);
        s_aw_valid = 1'b1; s_aw_addr = 32'h2010;
        exp_b.push_back(2'b00);
        #1;
        chk("t6_aw_ready", 64'(s_aw_ready), 64'd1);
        chk("t6_w_ready", 64'(s_w_ready), 64'd1);
        chk("t6_m_w_valid", 64'(m_w_valid), 64'b0100);
        chk("t6_m_aw_addr", 64'(m_aw_addr[2*AW +: AW]), 64'h10);
        @(negedge clk);
        idle();
        m_b_valid = 4'b0100; s_b_ready = 1'b1;
        #1;
        chk("t6_b_valid", 64'(s_b_valid), 64'd1);
        pop_b("t6_b_resp", s_b_resp);

        // ordering: three reads to target 0, then one to target 2
        do_reset();
        for (int k = 0; k < 3; k++) begin
            s_ar_valid = 1'b1; s_ar_addr = 32'h100 + 32'(4 * k);
            exp_r.push_back({2'b00, 32'hA0 + 32'(k)});
            #1;
            chk("t3_ar_ready_t0", 64'(s_ar_ready), 64'd1);
            @(negedge clk);
        end
        s_ar_addr = 32'h2000;
        #1;
        chk("t3_switch_blocked", 64'(s_ar_ready), 64'd0);
        chk("t3_switch_m_valid", 64'(m_ar_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            m_r_valid = 4'b0001; m_r_data[0*DW +: DW] = 32'hA0 + 32'(k); s_r_ready = 1'b1;
            #1;
            chk("t3_hold_ready", 64'(s_ar_ready), 64'd0);
            chk("t3_r_valid", 64'(s_r_valid), 64'd1);
            pop_r("t3_r", s_r_resp, s_r_data);
        end
        @(negedge clk);
        m_r_valid = '0; s_r_ready = 1'b0;
        #1;
        chk("t3_switch_ready", 64'(s_ar_ready), 64'd1);
        chk("t3_switch_valid", 64'(m_ar_valid), 64'b0100);
        chk("t3_switch_addr", 64'(m_ar_addr[2*AW +: AW]), 64'h0);

        // outstanding limit on the MAX_TRANS=2 instance
        do_reset();
        m_b_valid = '0;
        for (int k = 0; k < 3; k++) begin
            s_aw_valid = 1'b1; s_aw_addr = 32'h1000 + 32'(4 * k);
            s_w_valid = 1'b1; s_w_data = 32'(k);
            #1;
            chk("t4_lim_aw_ready", 64'(l_s_aw_ready), (k < 2) ? 64'd1 : 64'd0);
            if (k == 2) chk("t4_main_aw_ready", 64'(s_aw_ready), 64'd1);
            @(negedge clk);
        end
        s_aw_addr = 32'h1008;
        m_b_valid = 4'b0010; s_b_ready = 1'b1;
        exp_b.push_back(2'b00);
        #1;
        chk("t4_lim_still_blocked", 64'(l_s_aw_ready), 64'd0);
        chk("t4_lim_b_valid", 64'(l_s_b_valid), 64'd1);
        pop_b("t4_lim_b_resp", l_s_b_resp);
        @(negedge clk);
        m_b_valid = '0; s_b_ready = 1'b0;
        #1;
        chk("t4_lim_third_accepted", 64'(l_s_aw_ready), 64'd1);
        chk("t4_lim_third_w", 64'(l_s_w_ready), 64'd1);
        @(negedge clk);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
